// File: rtl/stack_pkg.sv
// Shared encodings for the hardware stack: operation codes, stack-memory write
// source select and the controller state encoding. The stack memory imports
// the same package so both sides agree on what a write strobe means.
package stack_pkg;

    // Operation requested on the op channel
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_POP2 = 2'b11
    } op_code_e;

    // Stack memory write source; NONE means the memory must not write
    typedef enum logic [1:0] {
        WSRC_NONE = 2'b00,
        WSRC_ALU  = 2'b01,
        WSRC_DMEM = 2'b10,
        WSRC_PC   = 2'b11
    } write_src_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Width of the address/stack-pointer buses seen outside the controller
    localparam int ADDR_W = 32;

    // Number of entries removed by a pop-type operation
    function automatic logic [1:0] pop_words(input op_code_e op);
        logic [1:0] n;
        case (op)
            OP_POP2: n = 2'd2;
            default: n = 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Hardware stack controller. Sequences PUSH / POP / POP2 against an external
// stack memory with a combinational two-word read port (mem_sp, mem_sp+1) and
// a one-cycle write strobe. sp counts occupied entries and always names the
// next free slot; the memory address is sp in idle/response, sp for a write
// and sp-1 / sp-2 for a read. Error flags are sticky until reset.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [1:0]        push_src,
    output logic [1:0]        mem_write_src,
    output logic [ADDR_W-1:0] mem_sp,
    input  logic [DATA_W-1:0] mem_read1,
    input  logic [DATA_W-1:0] mem_read2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic [ADDR_W-1:0] sp,
    output logic              full,
    output logic              empty,
    output logic              err_overflow,
    output logic              err_underflow
);

    // One extra bit so the counter can hold DEPTH itself (the full state)
    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TWO_C    = CNT_W'(2'd2);

    // FSM and registered outputs
    state_e              state_q;
    write_src_e          wsrc_q;
    logic                pop2_q;
    logic                op_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data1_q;
    logic [DATA_W-1:0]   rsp_data2_q;
    logic                err_ovf_q;
    logic                err_unf_q;

    // Stack pointer, memory address and occupancy flags
    logic [CNT_W-1:0]    sp_q;
    logic [CNT_W-1:0]    sp_d;
    logic [CNT_W-1:0]    mem_sp_q;
    logic [CNT_W-1:0]    mem_sp_d;
    logic                full_q;
    logic                empty_q;

    // Request decode
    op_code_e            op_s;
    write_src_e          src_s;
    logic                take_s;
    logic                is_pop_s;
    logic [CNT_W-1:0]    words_s;
    logic                push_ok_s;
    logic                push_ovf_s;
    logic                pop_ok_s;
    logic                pop_unf_s;

    // Decode the offered operation against the current occupancy (IDLE only)
    always_comb begin
        op_s       = op_code_e'(op_code);
        src_s      = write_src_e'(push_src);
        take_s     = op_valid && (state_q == ST_IDLE);
        is_pop_s   = (op_s == OP_POP) || (op_s == OP_POP2);
        words_s    = CNT_W'(pop_words(op_s));
        push_ok_s  = take_s && (op_s == OP_PUSH) && (sp_q != DEPTH_C) && (src_s != WSRC_NONE);
        push_ovf_s = take_s && (op_s == OP_PUSH) && (sp_q == DEPTH_C);
        pop_ok_s   = take_s && is_pop_s && (sp_q >= words_s);
        pop_unf_s  = take_s && is_pop_s && (sp_q < words_s);
    end

    // Next stack pointer: grows on leaving WRITE, shrinks on leaving READ
    always_comb begin
        sp_d = sp_q;
        case (state_q)
            ST_WRITE: sp_d = sp_q + ONE_C;
            ST_READ:  sp_d = sp_q - (pop2_q ? TWO_C : ONE_C);
            default:  sp_d = sp_q;
        endcase
    end

    // Next memory address: the lower of the popped words while reading, else sp
    always_comb begin
        if (pop_ok_s) begin
            mem_sp_d = sp_q - words_s;
        end else begin
            mem_sp_d = sp_d;
        end
    end

    // Stack pointer, memory address and full/empty flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q     <= ZERO_C;
            mem_sp_q <= ZERO_C;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            sp_q     <= sp_d;
            mem_sp_q <= mem_sp_d;
            full_q   <= (sp_d == DEPTH_C);
            empty_q  <= (sp_d == ZERO_C);
        end
    end

    // Controller FSM with registered handshake, strobe, response and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wsrc_q      <= WSRC_NONE;
            pop2_q      <= 1'b0;
            op_ready_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= {DATA_W{1'b0}};
            rsp_data2_q <= {DATA_W{1'b0}};
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (push_ok_s) begin
                        state_q    <= ST_WRITE;
                        wsrc_q     <= src_s;
                        op_ready_q <= 1'b0;
                    end else if (pop_ok_s) begin
                        state_q    <= ST_READ;
                        pop2_q     <= (op_s == OP_POP2);
                        op_ready_q <= 1'b0;
                    end else if (push_ovf_s) begin
                        // Rejected push is consumed; only the sticky flag records it
                        err_ovf_q  <= 1'b1;
                    end else if (pop_unf_s) begin
                        err_unf_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // Strobe lasts exactly this one cycle
                    wsrc_q     <= WSRC_NONE;
                    state_q    <= ST_IDLE;
                    op_ready_q <= 1'b1;
                end
                ST_READ: begin
                    // mem_read2 is the top entry when two words are popped
                    if (pop2_q) begin
                        rsp_data1_q <= mem_read2;
                        rsp_data2_q <= mem_read1;
                    end else begin
                        rsp_data1_q <= mem_read1;
                        rsp_data2_q <= {DATA_W{1'b0}};
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                        op_ready_q  <= 1'b1;
                    end else begin
                        state_q     <= ST_RESP;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    wsrc_q      <= WSRC_NONE;
                    op_ready_q  <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready      = op_ready_q;
    assign mem_write_src = wsrc_q;
    assign mem_sp        = {{(ADDR_W-CNT_W){1'b0}}, mem_sp_q};
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data1     = rsp_data1_q;
    assign rsp_data2     = rsp_data2_q;
    assign sp            = {{(ADDR_W-CNT_W){1'b0}}, sp_q};
    assign full          = full_q;
    assign empty         = empty_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule
